// File: rtl/axi_xbar_pkg.sv
// Shared types and constants for the 1-master / 2-slave AXI4-Lite crossbar.
// AXI_XBAR_DECERR_EN (see axi_lite_addr_decode / axi_lite_xbar) enables the internal DECERR target.
package axi_xbar_pkg;

  typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_ERR} xbar_sel_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WDATA, WR_BRESP} wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] S0_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] S0_MASK_DEF = 32'hF800_0000;
  localparam logic [31:0] S1_BASE_DEF = 32'hA000_0000;
  localparam logic [31:0] S1_MASK_DEF = 32'hFF00_0000;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus (32-bit address/data, 4-bit write mask). Handshake rule on every channel:
// a beat transfers on the clock edge where valid && ready; valid never waits on ready.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wmask, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wmask, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Base/mask address decoder; S0 is checked first and wins on overlap.
// Misses go to SEL_ERR with AXI_XBAR_DECERR_EN defined, otherwise to the device slave S1.
module axi_lite_addr_decode
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] S0_BASE = S0_BASE_DEF,
  parameter logic [31:0] S0_MASK = S0_MASK_DEF,
  parameter logic [31:0] S1_BASE = S1_BASE_DEF,
  parameter logic [31:0] S1_MASK = S1_MASK_DEF
) (
  input  logic [31:0] addr,
  output xbar_sel_t   sel
);

  always_comb begin
    if ((addr & S0_MASK) == S0_BASE) begin
      sel = SEL_S0;
    end else if ((addr & S1_MASK) == S1_BASE) begin
      sel = SEL_S1;
    end else begin
`ifdef AXI_XBAR_DECERR_EN
      sel = SEL_ERR;
`else
      sel = SEL_S1;
`endif
    end
  end

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-master / 2-slave AXI4-Lite router with independent read and write FSMs, one outstanding each.
// AXI_XBAR_DECERR_EN builds an internal target answering unmapped addresses with DECERR.
module axi_lite_xbar
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] S0_BASE = S0_BASE_DEF,
  parameter logic [31:0] S0_MASK = S0_MASK_DEF,
  parameter logic [31:0] S1_BASE = S1_BASE_DEF,
  parameter logic [31:0] S1_MASK = S1_MASK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  m,
  axi_lite_if.master s0,
  axi_lite_if.master s1,
  output rd_state_t  dbg_rd_state,
  output wr_state_t  dbg_wr_state
);

  rd_state_t rd_state_q, rd_state_d;
  wr_state_t wr_state_q, wr_state_d;
  xbar_sel_t rd_sel_q, rd_sel_d;
  xbar_sel_t wr_sel_q, wr_sel_d;
  xbar_sel_t ar_sel, aw_sel;

  axi_lite_addr_decode #(.S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK))
    u_ar_dec (.addr(m.araddr), .sel(ar_sel));
  axi_lite_addr_decode #(.S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK))
    u_aw_dec (.addr(m.awaddr), .sel(aw_sel));

  assign s0.araddr = m.araddr;
  assign s1.araddr = m.araddr;
  assign s0.awaddr = m.awaddr;
  assign s1.awaddr = m.awaddr;
  assign s0.wdata  = m.wdata;
  assign s1.wdata  = m.wdata;
  assign s0.wmask  = m.wmask;
  assign s1.wmask  = m.wmask;

  assign dbg_rd_state = rd_state_q;
  assign dbg_wr_state = wr_state_q;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_sel_d   = rd_sel_q;
    m.arready  = 1'b0;
    m.rvalid   = 1'b0;
    m.rdata    = 32'h0;
    m.rresp    = RESP_OKAY;
    s0.arvalid = 1'b0;
    s1.arvalid = 1'b0;
    s0.rready  = 1'b0;
    s1.rready  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        case (ar_sel)
          SEL_S0:  begin s0.arvalid = m.arvalid; m.arready = s0.arready; end
          SEL_S1:  begin s1.arvalid = m.arvalid; m.arready = s1.arready; end
`ifdef AXI_XBAR_DECERR_EN
          SEL_ERR: m.arready = 1'b1;
`endif
          default: ;
        endcase
        if (m.arvalid && m.arready) begin
          rd_sel_d   = ar_sel;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        case (rd_sel_q)
          SEL_S0: begin
            m.rvalid  = s0.rvalid;
            m.rdata   = s0.rdata;
            m.rresp   = s0.rresp;
            s0.rready = m.rready;
          end
          SEL_S1: begin
            m.rvalid  = s1.rvalid;
            m.rdata   = s1.rdata;
            m.rresp   = s1.rresp;
            s1.rready = m.rready;
          end
`ifdef AXI_XBAR_DECERR_EN
          SEL_ERR: begin
            m.rvalid = 1'b1;
            m.rresp  = RESP_DECERR;
          end
`endif
          default: ;
        endcase
        if (m.rvalid && m.rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
    // Handshake outputs are forced quiet for the whole reset window, not just after it.
    if (reset) begin
      m.arready  = 1'b0;
      m.rvalid   = 1'b0;
      s0.arvalid = 1'b0;
      s1.arvalid = 1'b0;
      s0.rready  = 1'b0;
      s1.rready  = 1'b0;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_sel_d   = wr_sel_q;
    m.awready  = 1'b0;
    m.wready   = 1'b0;
    m.bvalid   = 1'b0;
    m.bresp    = RESP_OKAY;
    s0.awvalid = 1'b0;
    s1.awvalid = 1'b0;
    s0.wvalid  = 1'b0;
    s1.wvalid  = 1'b0;
    s0.bready  = 1'b0;
    s1.bready  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        // In idle, W only moves together with its AW so a slave never holds orphan write data.
        case (aw_sel)
          SEL_S0: begin
            s0.awvalid = m.awvalid;
            m.awready  = s0.awready;
            s0.wvalid  = m.wvalid && m.awvalid && s0.awready;
            m.wready   = s0.wready && m.awvalid && s0.awready;
          end
          SEL_S1: begin
            s1.awvalid = m.awvalid;
            m.awready  = s1.awready;
            s1.wvalid  = m.wvalid && m.awvalid && s1.awready;
            m.wready   = s1.wready && m.awvalid && s1.awready;
          end
`ifdef AXI_XBAR_DECERR_EN
          SEL_ERR: begin
            m.awready = 1'b1;
            m.wready  = m.awvalid;
          end
`endif
          default: ;
        endcase
        if (m.awvalid && m.awready) begin
          wr_sel_d   = aw_sel;
          wr_state_d = (m.wvalid && m.wready) ? WR_BRESP : WR_WDATA;
        end
      end
      WR_WDATA: begin
        case (wr_sel_q)
          SEL_S0:  begin s0.wvalid = m.wvalid; m.wready = s0.wready; end
          SEL_S1:  begin s1.wvalid = m.wvalid; m.wready = s1.wready; end
`ifdef AXI_XBAR_DECERR_EN
          SEL_ERR: m.wready = 1'b1;
`endif
          default: ;
        endcase
        if (m.wvalid && m.wready) wr_state_d = WR_BRESP;
      end
      WR_BRESP: begin
        case (wr_sel_q)
          SEL_S0: begin m.bvalid = s0.bvalid; m.bresp = s0.bresp; s0.bready = m.bready; end
          SEL_S1: begin m.bvalid = s1.bvalid; m.bresp = s1.bresp; s1.bready = m.bready; end
`ifdef AXI_XBAR_DECERR_EN
          SEL_ERR: begin m.bvalid = 1'b1; m.bresp = RESP_DECERR; end
`endif
          default: ;
        endcase
        if (m.bvalid && m.bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (reset) begin
      m.awready  = 1'b0;
      m.wready   = 1'b0;
      m.bvalid   = 1'b0;
      s0.awvalid = 1'b0;
      s1.awvalid = 1'b0;
      s0.wvalid  = 1'b0;
      s1.wvalid  = 1'b0;
      s0.bready  = 1'b0;
      s1.bready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_sel_q   <= SEL_S0;
      wr_sel_q   <= SEL_S0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_sel_q   <= rd_sel_d;
      wr_sel_q   <= wr_sel_d;
    end
  end

endmodule
